adder_share_arbiter: RTL and testbench

- Shares one NBITS-wide ripple-carry adder instance between NREQ requesters using round-robin arbitration and valid/ready handshakes.
- Operands are registered into the adder inputs and held for SETTLE_CYC cycles so the ripple path is treated as a multicycle path. The result is then captured into a response register.
- Sits between operand-producing blocks and the shared adder. It is the only driver of the adder's inputs.

---
 rtl/adder_share_arbiter.sv | 169 ++++++++++++++++
 tb/tb_adder_share_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one ripple-carry adder among NREQ requesters, with a multicycle
// settle window. Optional counters enabled by defining ADD_SHARE_STATS_EN.
module adder_share_arbiter #(
    parameter int unsigned NBITS      = 8,
    parameter int unsigned SIGND      = 0,
    parameter int unsigned NREQ       = 4,
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*NBITS-1:0]     req_a,
    input  logic [NREQ*NBITS-1:0]     req_b,
    input  logic [NREQ-1:0]           req_cin,
    output logic [NREQ-1:0]           req_ready,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [NBITS-1:0]          rsp_sum,
    output logic                      rsp_cout,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic                      busy
`ifdef ADD_SHARE_STATS_EN
    ,
    output logic [15:0]               op_count,
    output logic [15:0]               stall_count
`endif
);

    localparam int unsigned IDW = $clog2(NREQ);
    localparam int unsigned CW  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    typedef enum logic [1:0] {StIdle, StSettle, StResp} state_e;

    state_e           r_state, w_state_next;
    logic [NBITS-1:0] r_op_a, r_op_b;
    logic             r_op_cin;
    logic [CW-1:0]    r_cnt;
    logic [IDW-1:0]   r_last_grant;
    logic             r_rsp_valid;
    logic [NBITS-1:0] r_rsp_sum;
    logic             r_rsp_cout;
    logic [IDW-1:0]   r_rsp_id;

    logic [NREQ-1:0]  w_grant;
    logic [IDW-1:0]   w_gnt_id;
    logic [IDW-1:0]   w_cand;
    logic             w_gnt_any;

    // Search upward from the slot after the last winner, wrapping modulo NREQ.
    always_comb begin
        w_grant   = '0;
        w_gnt_id  = '0;
        w_cand    = '0;
        w_gnt_any = 1'b0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            w_cand = IDW'((32'(r_last_grant) + k) % NREQ);
            if (!w_gnt_any && req_valid[w_cand]) begin
                w_gnt_any = 1'b1;
                w_gnt_id  = w_cand;
            end
        end
        if (r_state != StIdle) begin
            w_gnt_any = 1'b0;
        end
        if (w_gnt_any) begin
            w_grant[w_gnt_id] = 1'b1;
        end
    end

    // Shared ripple-carry adder; its inputs are only ever the operand registers.
    logic [NBITS:0]   w_carry;
    logic [NBITS-1:0] w_sum;
    logic             w_ovf;
    logic             w_cout;

    assign w_carry[0] = r_op_cin;
    for (genvar gi = 0; gi < NBITS; gi++) begin : g_rca
        assign w_sum[gi]     = r_op_a[gi] ^ r_op_b[gi] ^ w_carry[gi];
        assign w_carry[gi+1] = (r_op_a[gi] & r_op_b[gi]) |
                               (w_carry[gi] & (r_op_a[gi] ^ r_op_b[gi]));
    end

    assign w_ovf  = (~r_op_a[NBITS-1] & ~r_op_b[NBITS-1] &  w_sum[NBITS-1]) |
                    ( r_op_a[NBITS-1] &  r_op_b[NBITS-1] & ~w_sum[NBITS-1]);
    assign w_cout = (SIGND != 0) ? w_ovf : w_carry[NBITS];

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:   if (w_gnt_any) w_state_next = StSettle;
            StSettle: if (r_cnt == '0) w_state_next = StResp;
            StResp:   if (rsp_ready) w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_op_cin     <= 1'b0;
            r_cnt        <= '0;
            r_last_grant <= IDW'(NREQ - 1);
            r_rsp_valid  <= 1'b0;
            r_rsp_sum    <= '0;
            r_rsp_cout   <= 1'b0;
            r_rsp_id     <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                StIdle: begin
                    if (w_gnt_any) begin
                        r_op_a       <= req_a[w_gnt_id*NBITS +: NBITS];
                        r_op_b       <= req_b[w_gnt_id*NBITS +: NBITS];
                        r_op_cin     <= req_cin[w_gnt_id];
                        r_last_grant <= w_gnt_id;
                        r_cnt        <= CW'(SETTLE_CYC - 1);
                    end
                end
                StSettle: begin
                    if (r_cnt == '0) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_sum   <= w_sum;
                        r_rsp_cout  <= w_cout;
                        r_rsp_id    <= r_last_grant;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready = w_grant;
    assign rsp_valid = r_rsp_valid;
    assign rsp_sum   = r_rsp_sum;
    assign rsp_cout  = r_rsp_cout;
    assign rsp_id    = r_rsp_id;
    assign busy      = (r_state != StIdle);

`ifdef ADD_SHARE_STATS_EN
    logic [15:0] r_op_count, r_stall_count;

    // rsp_valid is high exactly while in StResp, so the state alone qualifies the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_count    <= '0;
            r_stall_count <= '0;
        end else if (r_state == StResp) begin
            if (rsp_ready) begin
                if (r_op_count != 16'hFFFF) r_op_count <= r_op_count + 16'd1;
            end else begin
                if (r_stall_count != 16'hFFFF) r_stall_count <= r_stall_count + 16'd1;
            end
        end
    end

    assign op_count    = r_op_count;
    assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter: an unsigned (SIGND=0) and a signed (SIGND=1) instance
// share the same stimulus; expected values are hand-computed.
module tb_adder_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  req_valid;
    logic [31:0] req_a, req_b;
    logic [3:0]  req_cin;
    logic        rsp_ready;

    logic [3:0]  req_ready, s_req_ready;
    logic        rsp_valid, s_rsp_valid;
    logic [7:0]  rsp_sum, s_rsp_sum;
    logic        rsp_cout, s_rsp_cout;
    logic [1:0]  rsp_id, s_rsp_id;
    logic        busy, s_busy;
`ifdef ADD_SHARE_STATS_EN
    logic [15:0] op_count, stall_count, s_op_count, s_stall_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    adder_share_arbiter #(.NBITS(8), .SIGND(0), .NREQ(4), .SETTLE_CYC(2)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_cin(req_cin), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_id(rsp_id), .busy(busy)
`ifdef ADD_SHARE_STATS_EN
        , .op_count(op_count), .stall_count(stall_count)
`endif
    );

    adder_share_arbiter #(.NBITS(8), .SIGND(1), .NREQ(4), .SETTLE_CYC(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_cin(req_cin), .req_ready(s_req_ready), .rsp_valid(s_rsp_valid),
        .rsp_ready(rsp_ready), .rsp_sum(s_rsp_sum), .rsp_cout(s_rsp_cout), .rsp_id(s_rsp_id),
        .busy(s_busy)
`ifdef ADD_SHARE_STATS_EN
        , .op_count(s_op_count), .stall_count(s_stall_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic [7:0] a, input logic [7:0] b,
                           input logic cin);
        req_valid          = '0;
        req_valid[id]      = 1'b1;
        req_a[id*8 +: 8]   = a;
        req_b[id*8 +: 8]   = b;
        req_cin[id]        = cin;
    endtask

    // One full transaction with rsp_ready high: grant, two settle cycles, response, handshake.
    task automatic do_op(input int id, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic [7:0] exp_sum, input logic exp_cout,
                         input logic exp_ovf);
        set_req(id, a, b, cin);
        #1;
        check("grant_onehot", 32'(req_ready), 32'(1) << id);
        tick();
        req_valid = '0;
        check("settle_busy", 32'(busy), 1);
        check("settle_ready", 32'(req_ready), 0);
        tick();
        check("settle_no_rsp", 32'(rsp_valid), 0);
        tick();
        check("rsp_valid", 32'(rsp_valid), 1);
        check("rsp_sum", 32'(rsp_sum), 32'(exp_sum));
        check("rsp_cout", 32'(rsp_cout), 32'(exp_cout));
        check("rsp_id", 32'(rsp_id), 32'(id));
        check("s_rsp_sum", 32'(s_rsp_sum), 32'(exp_sum));
        check("s_rsp_ovf", 32'(s_rsp_cout), 32'(exp_ovf));
        tick();
        check("rsp_cleared", 32'(rsp_valid), 0);
        check("sum_retained", 32'(rsp_sum), 32'(exp_sum));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_rsp;
        int n_g;
        int last_g;

        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        rsp_ready = 1'b1;

        #2 rst_n = 1'b0;
        tick();
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_sum", 32'(rsp_sum), 0);
        check("rst_id", 32'(rsp_id), 0);
        check("rst_ready", 32'(req_ready), 0);
        #2 rst_n = 1'b1;
        tick();

        do_op(0, 8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0);
        do_op(2, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0);
        do_op(0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        do_op(0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);

        // Backpressure from a fresh reset so the stats start at zero.
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        rsp_ready = 1'b0;
        set_req(1, 8'h10, 8'h20, 1'b0);
        #1;
        check("bp_grant", 32'(req_ready), 32'h2);
        tick();
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(rsp_valid), 1);
            check("bp_sum", 32'(rsp_sum), 32'h30);
            check("bp_id", 32'(rsp_id), 1);
            check("bp_no_grant", 32'(req_ready), 0);
            tick();
        end
`ifdef ADD_SHARE_STATS_EN
        check("bp_stall_count", 32'(stall_count), 5);
        check("bp_op_count_pre", 32'(op_count), 0);
`endif
        rsp_ready = 1'b1;
        #1;
        check("bp_still_valid", 32'(rsp_valid), 1);
        tick();
        check("bp_released", 32'(rsp_valid), 0);
        check("bp_regrant", 32'(req_ready), 32'h2);
        check("bp_sum_kept", 32'(rsp_sum), 32'h30);
`ifdef ADD_SHARE_STATS_EN
        check("bp_op_count", 32'(op_count), 1);
        check("bp_stall_final", 32'(stall_count), 5);
`endif

        // Grant req1 again, then reset one cycle into SETTLE.
        tick();
        req_valid = '0;
        check("mid_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(rsp_valid), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_sum", 32'(rsp_sum), 0);
        check("mid_rst_cout", 32'(rsp_cout), 0);
        check("mid_rst_id", 32'(rsp_id), 0);
        check("mid_rst_ready", 32'(req_ready), 0);
`ifdef ADD_SHARE_STATS_EN
        check("mid_rst_ops", 32'(op_count), 0);
        check("mid_rst_stall", 32'(stall_count), 0);
`endif
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mid_rst_hold_valid", 32'(rsp_valid), 0);
        end

        // Fairness: all four requesters valid, operands chosen so sum = id * 17.
        req_valid = 4'hF;
        req_cin   = '0;
        for (int i = 0; i < 4; i++) begin
            req_a[i*8 +: 8] = 8'(i * 16);
            req_b[i*8 +: 8] = 8'(i);
        end
        #2 rst_n = 1'b1;
        #1;
        check("post_rst_prio0", 32'(req_ready), 32'h1);

        n_rsp  = 0;
        n_g    = 0;
        last_g = 0;
        for (int cyc = 0; cyc < 60 && n_rsp < 8; cyc++) begin
            if (req_ready != '0) begin
                if (n_g > 0) check("fair_gap", 32'(cyc - last_g), 4);
                last_g = cyc;
                n_g++;
            end
            if (rsp_valid) begin
                check("fair_id", 32'(rsp_id), 32'(n_rsp % 4));
                check("fair_sum", 32'(rsp_sum), 32'((n_rsp % 4) * 17));
                n_rsp++;
            end
            tick();
        end
        check("fair_rsp_count", 32'(n_rsp), 8);
        req_valid = '0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
